// File: rtl/serial_adder_n_pkg.sv
`default_nettype none
// ============================================================================
// Package : serial_arith_pkg
// Purpose : Shared definitions for the bit-serial arithmetic blocks.
//           - state_t   : 2-bit encoding of the IDLE / RUN / DONE sequencer
//           - cnt_width : bit-counter width able to hold 0..w without wrapping
// Revision: 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must reach w-1 without wrapping; sizing for w+1 values keeps a
  // spare count so the terminal compare never aliases onto zero.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/serial_adder_n_if.sv
`default_nettype none
// ============================================================================
// Interface : serial_adder_n_if
// Purpose   : Start/busy/done request bus of the bit-serial adder.
// Signals   : start, sub, a, b, cin   - request side (master drives)
//             busy, done, sum, cout,
//             ovf                     - response side (slave drives)
// Modports  : master (requester), slave (adder)
// Revision  : 1.0 - initial release
// ============================================================================
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface : serial_adder_n_if
`default_nettype wire

// File: rtl/serial_adder_n_full_adder_bit.sv
`default_nettype none
// ============================================================================
// Module  : full_adder_bit
// Purpose : One-bit full adder built from two half-adder gate pairs and an
//           OR gate merging the two partial carries.
// Ports   : a, b, ci (in)  - operand bits and carry-in
//           s, co    (out) - sum bit and carry-out
// Revision: 1.0 - initial release
// ============================================================================
module full_adder_bit (
  input  wire logic a,
  input  wire logic b,
  input  wire logic ci,
  output logic      s,
  output logic      co
);

  logic w_ha0_s;
  logic w_ha0_c;
  logic w_ha1_c;

  // First half adder: a + b
  assign w_ha0_s = a ^ b;
  assign w_ha0_c = a & b;

  // Second half adder: partial sum + carry-in
  assign s       = w_ha0_s ^ ci;
  assign w_ha1_c = w_ha0_s & ci;

  // At most one half adder can generate a carry, so OR is the majority
  assign co      = w_ha0_c | w_ha1_c;

endmodule : full_adder_bit
`default_nettype wire

// File: rtl/serial_adder_n.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_n
// Purpose : Bit-serial adder/subtractor. One result bit per clock, LSB first,
//           through a single full-adder cell and a carry flip-flop.
//           sub=0 : sum = a + b + cin
//           sub=1 : sum = a - b  (b inverted, carry seeded with 1)
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - serial_adder_n_if.slave (start/sub/a/b/cin in,
//                  busy/done/sum/cout/ovf out)
// Timing  : start accepted at edge E0, done high in the cycle after E_WIDTH,
//           busy high for exactly WIDTH cycles.
// Revision: 1.0 - initial release
// ============================================================================
module serial_adder_n
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  serial_adder_n_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] res_next;

  full_adder_bit u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_next)
  );

  assign res_next = {s_bit, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            // Subtraction is a + ~b + 1: invert b here, seed carry with 1
            a_sh     <= bus.a;
            b_sh     <= bus.b ^ {WIDTH{bus.sub}};
            carry    <= bus.sub ? 1'b1 : bus.cin;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end

        RUN: begin
          carry  <= c_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // On the MSB step the carry register still holds the carry into
            // the MSB, so overflow is that carry XOR the MSB carry-out.
            bus.sum  <= res_next;
            bus.cout <= c_next;
            bus.ovf  <= carry ^ c_next;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_adder_n
`default_nettype wire
